// File: rtl/vga_pkg.sv
// Shared timing constants, register map and RAM slot encoding for the VGA framebuffer controller.
package vga_pkg;

  localparam int H_VISIBLE    = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;

  localparam int V_VISIBLE    = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;

  typedef enum logic [2:0] {
    REG_X_LO   = 3'd0,
    REG_X_HI   = 3'd1,
    REG_Y      = 3'd2,
    REG_DATA   = 3'd3,
    REG_STATUS = 3'd4
  } reg_idx_e;

  typedef enum logic {
    SLOT_VIDEO = 1'b0,
    SLOT_MCU   = 1'b1
  } slot_e;

endpackage

// File: rtl/vga_if.sv
// Display/SRAM control outputs and MCU register-port controls of the VGA controller.
interface vga_if;
  logic        hSync;
  logic        vSync;
  logic [7:0]  videoOutputData;
  logic [16:0] ramAddress;
  logic        ramWriteEnable;
  logic        ramOutputEnable;
  logic        mpuChipSelect;
  logic        mpuWriteEnable;
  logic [2:0]  mpuRegisterSelect;

  modport master (
    output hSync, vSync, videoOutputData, ramAddress, ramWriteEnable, ramOutputEnable,
    input  mpuChipSelect, mpuWriteEnable, mpuRegisterSelect
  );

  modport slave (
    input  hSync, vSync, videoOutputData, ramAddress, ramWriteEnable, ramOutputEnable,
    output mpuChipSelect, mpuWriteEnable, mpuRegisterSelect
  );
endinterface

// File: rtl/vga_timing.sv
// 640x480@60 raster counters with sync, visible flag and 2x-scaled framebuffer coordinates.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  output logic [8:0] fb_x_o,
  output logic [7:0] fb_y_o,
  output logic       phase_o,
  output logic       visible_o,
  output logic       hsync_n_o,
  output logic       vsync_n_o
);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign fb_x_o    = h_q[9:1];
  assign fb_y_o    = v_q[8:1];
  assign phase_o   = h_q[0];
  assign visible_o = (h_q < 10'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));
  assign hsync_n_o = !((h_q >= 10'(H_SYNC_START)) && (h_q < 10'(H_SYNC_END)));
  assign vsync_n_o = !((v_q >= 10'(V_SYNC_START)) && (v_q < 10'(V_SYNC_END)));

endmodule

// File: rtl/vga_controller.sv
// Framebuffer VGA controller: 320x240x8 SRAM image scaled 2x, SRAM shared with an MCU port.
// Optional VGA_AUTOINC_EN: X/Y advance after every accepted data-register write.
module vga_controller
  import vga_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  vga_if.master    bus,
  inout  wire [7:0] ramData,
  inout  wire [7:0] mpuData
);

  logic [8:0] fb_x;
  logic [7:0] fb_y;
  logic       phase, visible, hsync_n, vsync_n;
  slot_e      slot;

  vga_timing u_timing (
    .clock_i   (clock),
    .reset_i   (reset),
    .fb_x_o    (fb_x),
    .fb_y_o    (fb_y),
    .phase_o   (phase),
    .visible_o (visible),
    .hsync_n_o (hsync_n),
    .vsync_n_o (vsync_n)
  );

  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [16:0] waddr_q, waddr_d;
  logic        busy_q, busy_d;
  logic        mpu_wr_q;
  logic        mpu_wr, wr_commit, wr_done;
  logic [7:0]  rd_data;

  logic [16:0] ram_addr_q, ram_addr_d;
  logic        ram_oe_q, ram_oe_d;
  logic        ram_we_q, ram_we_d;

  logic [7:0]  pix_p2_q;
  logic        vld_p1_q, vld_p2_q;
  logic        hs_p1_q, hs_p2_q, vs_p1_q, vs_p2_q;

  assign mpu_wr    = bus.mpuChipSelect & bus.mpuWriteEnable;
  assign wr_commit = mpu_wr & ~mpu_wr_q;
  // WE is low for exactly one cycle, so this doubles as the write-complete pulse.
  assign wr_done   = ~ram_we_q;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    busy_d  = busy_q;
    if (wr_done) busy_d = 1'b0;
    if (wr_commit) begin
      case (bus.mpuRegisterSelect)
        REG_X_LO: x_d[7:0] = mpuData;
        REG_X_HI: x_d[8]   = mpuData[0];
        REG_Y:    y_d      = mpuData;
        REG_DATA: begin
          if (!busy_q) begin
            wdata_d = mpuData;
            waddr_d = {y_q, x_q};
            busy_d  = 1'b1;
`ifdef VGA_AUTOINC_EN
            if (x_q == 9'(FB_WIDTH - 1)) begin
              x_d = '0;
              y_d = (y_q == 8'(FB_HEIGHT - 1)) ? '0 : y_q + 8'd1;
            end else begin
              x_d = x_q + 9'd1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.mpuRegisterSelect)
      REG_X_LO:   rd_data = x_q[7:0];
      REG_X_HI:   rd_data = {7'd0, x_q[8]};
      REG_Y:      rd_data = y_q;
      REG_DATA:   rd_data = wdata_q;
      REG_STATUS: rd_data = {7'd0, busy_q};
      default:    rd_data = '0;
    endcase
  end

  assign slot = slot_e'(phase);

  // Even columns fetch the pixel pair for h and h+1; odd columns carry a pending MCU write.
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_oe_d   = 1'b1;
    ram_we_d   = 1'b1;
    if (slot == SLOT_VIDEO) begin
      if (visible) begin
        ram_addr_d = {fb_y, fb_x};
        ram_oe_d   = 1'b0;
      end
    end else if (busy_q && ram_we_q) begin
      ram_addr_d = waddr_q;
      ram_we_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      wdata_q    <= '0;
      waddr_q    <= '0;
      busy_q     <= 1'b0;
      mpu_wr_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_oe_q   <= 1'b1;
      ram_we_q   <= 1'b1;
      pix_p2_q   <= '0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      hs_p1_q    <= 1'b1;
      hs_p2_q    <= 1'b1;
      vs_p1_q    <= 1'b1;
      vs_p2_q    <= 1'b1;
    end else begin
      x_q        <= x_d;
      y_q        <= y_d;
      wdata_q    <= wdata_d;
      waddr_q    <= waddr_d;
      busy_q     <= busy_d;
      mpu_wr_q   <= mpu_wr;
      // stage 1: RAM address/strobes registered, raster flags follow
      ram_addr_q <= ram_addr_d;
      ram_oe_q   <= ram_oe_d;
      ram_we_q   <= ram_we_d;
      vld_p1_q   <= visible;
      hs_p1_q    <= hsync_n;
      vs_p1_q    <= vsync_n;
      // stage 2: SRAM byte captured and held across both output pixels
      if (!ram_oe_q) pix_p2_q <= ramData;
      vld_p2_q   <= vld_p1_q;
      hs_p2_q    <= hs_p1_q;
      vs_p2_q    <= vs_p1_q;
    end
  end

  assign bus.hSync           = hs_p2_q;
  assign bus.vSync           = vs_p2_q;
  assign bus.videoOutputData = vld_p2_q ? pix_p2_q : 8'd0;
  assign bus.ramAddress      = ram_addr_q;
  assign bus.ramWriteEnable  = ram_we_q;
  assign bus.ramOutputEnable = ram_oe_q;

  assign ramData = ram_we_q ? 8'bz : wdata_q;
  assign mpuData = (bus.mpuChipSelect && !bus.mpuWriteEnable) ? rd_data : 8'bz;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: raster/pixel reference model, MCU write path, drop and reset cases.
module tb_vga_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  vga_if bus();
  wire [7:0] ramData;
  wire [7:0] mpuData;
  logic [7:0] mpu_drv_val = 8'd0;
  logic       mpu_drv_en  = 1'b0;

  logic [7:0] mem [0:131071];
  typedef struct packed { logic [16:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];

  int checks = 0;
  int errors = 0;
  int mx = 0;
  int my = 0;

  vga_controller dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .ramData (ramData),
    .mpuData (mpuData)
  );

  always #5 clock = ~clock;

  // Asynchronous SRAM model
  assign ramData = (bus.ramOutputEnable === 1'b0 && bus.ramWriteEnable === 1'b1) ? mem[bus.ramAddress] : 8'bz;
  assign mpuData = mpu_drv_en ? mpu_drv_val : 8'bz;

  always @(negedge clock) begin
    if (bus.ramWriteEnable === 1'b0) begin
      mem[bus.ramAddress] <= ramData;
      wlog.push_back({bus.ramAddress, ramData});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 1ms");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mpu_read(input logic [2:0] r, output logic [7:0] d);
    bus.mpuRegisterSelect = r;
    bus.mpuWriteEnable    = 1'b0;
    bus.mpuChipSelect     = 1'b1;
    #1;
    d = mpuData;
    bus.mpuChipSelect     = 1'b0;
    bus.mpuWriteEnable    = 1'b1;
  endtask

  task automatic mpu_pulse(input logic [2:0] r, input logic [7:0] d);
    bus.mpuRegisterSelect = r;
    bus.mpuWriteEnable    = 1'b1;
    mpu_drv_val           = d;
    mpu_drv_en            = 1'b1;
    bus.mpuChipSelect     = 1'b1;
    tick();
    bus.mpuChipSelect     = 1'b0;
    mpu_drv_en            = 1'b0;
  endtask

  task automatic mpu_write(input logic [2:0] r, input logic [7:0] d);
    mpu_pulse(r, d);
    tick();
  endtask

  // Model of the address pointer after an accepted data write
  function automatic void model_accept();
`ifdef VGA_AUTOINC_EN
    if (mx == 319) begin
      mx = 0;
      my = (my == 239) ? 0 : (my + 1) % 256;
    end else begin
      mx = (mx + 1) % 512;
    end
`endif
  endfunction

  task automatic set_xy(input int x, input int y);
    mpu_write(3'd0, 8'(x % 256));
    mpu_write(3'd1, 8'(x / 256));
    mpu_write(3'd2, 8'(y));
    mx = x;
    my = y;
  endtask

  task automatic check_xy();
    logic [7:0] rd;
    mpu_read(3'd0, rd); check("reg_x_lo", 32'(rd), 32'(mx % 256));
    mpu_read(3'd1, rd); check("reg_x_hi", 32'(rd), 32'(mx / 256));
    mpu_read(3'd2, rd); check("reg_y", 32'(rd), 32'(my));
  endtask

  task automatic wait_we(output int lat);
    logic [7:0] s;
    lat = -1;
    for (int i = 1; i <= 3 && lat < 0; i++) begin
      tick();
      if (bus.ramWriteEnable === 1'b0) lat = i;
      else begin
        mpu_read(3'd4, s);
        check("busy_pending", 32'(s), 32'd1);
      end
    end
    check("we_latency_1_2", (lat >= 1 && lat <= 2) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic data_write(input logic [7:0] d, output logic [16:0] got);
    logic [16:0] ea;
    logic [7:0]  rd;
    int          lat;
    ea = 17'(my * 512 + mx);
    wlog.delete();
    mpu_pulse(3'd3, d);
    model_accept();
    wait_we(lat);
    check("wr_addr", 32'(bus.ramAddress), 32'(ea));
    check("wr_data", 32'(ramData), 32'(d));
    check("wr_oe_high", 32'(bus.ramOutputEnable), 32'd1);
    mpu_read(3'd4, rd); check("busy_during_we", 32'(rd), 32'd1);
    tick();
    check("we_one_cycle", 32'(bus.ramWriteEnable), 32'd1);
    mpu_read(3'd4, rd); check("busy_cleared", 32'(rd), 32'd0);
    check("wr_count", 32'(wlog.size()), 32'd1);
    got = wlog[0].a;
    check("sram_byte", 32'(mem[ea]), 32'(d));
    mpu_read(3'd3, rd); check("reg_data_rb", 32'(rd), 32'(d));
    check_xy();
  endtask

  task automatic check_reset_state();
    logic [7:0] rd;
    check("rst_hsync", 32'(bus.hSync), 32'd1);
    check("rst_vsync", 32'(bus.vSync), 32'd1);
    check("rst_video", 32'(bus.videoOutputData), 32'd0);
    check("rst_we", 32'(bus.ramWriteEnable), 32'd1);
    check("rst_oe", 32'(bus.ramOutputEnable), 32'd1);
    check("rst_addr", 32'(bus.ramAddress), 32'd0);
    for (int r = 0; r < 5; r++) begin
      mpu_read(3'(r), rd);
      check("rst_reg", 32'(rd), 32'd0);
    end
  endtask

  // Raster reference: what the output must show for display position c (c<0 means still in reset latency)
  task automatic model_px(input int c, output logic [7:0] px, output logic hs, output logic vs);
    int h, v;
    px = 8'd0; hs = 1'b1; vs = 1'b1;
    if (c >= 0) begin
      h  = c % 800;
      v  = (c / 800) % 525;
      hs = !(h >= 656 && h < 752);
      vs = !(v >= 490 && v < 492);
      if (h < 640 && v < 480) px = mem[(v / 2) * 512 + h / 2];
    end
  endtask

  initial begin
    logic [7:0]  px, rd;
    logic        hs, vs;
    logic [16:0] a1, a2;
    int          lat;

    bus.mpuChipSelect     = 1'b0;
    bus.mpuWriteEnable    = 1'b1;
    bus.mpuRegisterSelect = 3'd0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h3C;

    repeat (3) tick();
    check_reset_state();
    reset = 1'b0;

    for (int n = 0; n < 2600; n++) begin
      model_px(n - 2, px, hs, vs);
      check("pixel", 32'(bus.videoOutputData), 32'(px));
      check("hsync", 32'(bus.hSync), 32'(hs));
      check("vsync", 32'(bus.vSync), 32'(vs));
      if (n == 2 || n == 3 || n == 802 || n == 803)
        check("pixel_3c", 32'(bus.videoOutputData), 32'h3C);
      if (n == 657 || n == 658)
        check("first_hsync_edge", 32'(bus.hSync), (n == 658) ? 32'd0 : 32'd1);
      tick();
    end

    set_xy(5, 3);
    check_xy();
    data_write(8'hA5, a1);
    check("directed_addr", 32'(a1), 32'h00605);

    for (int k = 0; k < 6; k++) begin
      set_xy(int'($urandom_range(0, 511)), int'($urandom_range(0, 255)));
      data_write(8'($urandom), a1);
    end

    set_xy(319, 239);
    data_write(8'h11, a1);
    data_write(8'h22, a2);
    check("edge_addr_1", 32'(a1), 32'h1DF3F);
`ifdef VGA_AUTOINC_EN
    check("edge_addr_2", 32'(a2), 32'h00000);
`else
    check("edge_addr_2", 32'(a2), 32'h1DF3F);
`endif

    set_xy(7, 9);
    wlog.delete();
    mpu_pulse(3'd3, 8'h5A);
    model_accept();
    tick();
    mpu_pulse(3'd3, 8'hC3);
    repeat (6) tick();
    check("drop_count", 32'(wlog.size()), 32'd1);
    check("drop_addr", 32'(wlog[0].a), 32'(9 * 512 + 7));
    check("drop_data", 32'(wlog[0].d), 32'h5A);
    mpu_read(3'd3, rd); check("drop_reg_data", 32'(rd), 32'h5A);
    check_xy();

    set_xy(100, 50);
    wlog.delete();
    mpu_pulse(3'd3, 8'h99);
    wait_we(lat);
    reset = 1'b1;
    #1;
    check("rst_we_async", 32'(bus.ramWriteEnable), 32'd1);
    repeat (2) tick();
    reset = 1'b0;
    check_reset_state();
    repeat (12) tick();
    check("rst_no_write", 32'(wlog.size()), 32'd0);
    mpu_read(3'd4, rd); check("rst_busy_idle", 32'(rd), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
